// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcodes, FSM states, write-back selects and trap causes.
// Opcode classification helpers are shared by the sequencer and later pipeline stages.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } ctrl_state_t;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      TC_ILLEGAL  = 2'd0,
      TC_MISALIGN = 2'd1,
      TC_TIMEOUT  = 2'd2
   } trap_cause_t;

   function automatic logic op_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
         default:                           op_legal = 1'b0;
      endcase
   endfunction

   function automatic wb_sel_t op_wb_sel(input logic [6:0] op);
      case (op)
         OP_LOAD:         op_wb_sel = WB_LOAD;
         OP_JAL, OP_JALR: op_wb_sel = WB_PC4;
         OP_LUI, OP_AUIPC: op_wb_sel = WB_IMM;
         default:         op_wb_sel = WB_ALU;
      endcase
   endfunction

   function automatic logic op_writes(input logic [6:0] op);
      op_writes = (op != OP_STORE) && (op != OP_BRANCH);
   endfunction

endpackage

// File: rtl/rv_next_pc.sv
// Next-PC selection for jal/jalr/branch plus misalignment detection on taken transfers.
// Purely combinational so the pipelined core can reuse it in its execute stage.
module rv_next_pc
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [6:0]      opcode,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_val,
   input  logic            cmp_flag,
   output logic [XLEN-1:0] target_c,
   output logic            taken_c,
   output logic            misaligned_c
);

   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] rel_pc;
   logic [XLEN-1:0] jalr_pc;

   always_comb begin
      seq_pc   = pc + XLEN'(4);
      rel_pc   = pc + imm;
      jalr_pc  = (rs1_val + imm) & ~XLEN'(1);
      target_c = seq_pc;
      taken_c  = 1'b0;
      case (opcode)
         OP_JAL: begin
            target_c = rel_pc;
            taken_c  = 1'b1;
         end
         OP_JALR: begin
            target_c = jalr_pc;
            taken_c  = 1'b1;
         end
         OP_BRANCH: begin
            if (cmp_flag) begin
               target_c = rel_pc;
               taken_c  = 1'b1;
            end
         end
         default: ;
      endcase
      // Sequential pc+4 is always aligned, so only taken transfers can fault.
      misaligned_c = taken_c && (target_c[1:0] != 2'b00);
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Handshaked multicycle sequencer and PC unit for the RV32I core.
// Opcode-dependent FETCH/DECODE/EXEC/MEM/WB walk with traps on illegal op, misalignment, bus timeout.
module rv_multicycle_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic             cmp_flag,
   input  logic             mem_ack,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_load,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             alu_src_b,
   output logic [CNT_W-1:0] retired,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   ctrl_state_t       state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [XLEN-1:0]   target_q;
   wb_sel_t           wb_sel_q;
   trap_cause_t       cause_q;
   logic              writes_q;
   logic              store_q;

   logic [XLEN-1:0]   target_c;
   logic              taken_c;
   logic              misaligned_c;

   rv_next_pc #(.XLEN(XLEN)) u_next_pc (
      .opcode       (opcode),
      .pc           (pc),
      .imm          (imm),
      .rs1_val      (rs1_val),
      .cmp_flag     (cmp_flag),
      .target_c     (target_c),
      .taken_c      (taken_c),
      .misaligned_c (misaligned_c)
   );

   // Strobes decode straight from the state register; rst gating drops a live request at once.
   assign mem_req      = ((state == ST_FETCH) || (state == ST_MEM)) && !rst;
   assign mem_addr_sel = (state == ST_MEM);
   assign mem_we       = (state == ST_MEM) && store_q;
   assign ir_load      = (state == ST_FETCH) && mem_ack && !rst;
   assign reg_we       = (state == ST_WB) && writes_q;
   assign wb_sel       = wb_sel_q;
   assign alu_src_b    = (opcode != OP_R);
   assign pc_plus4     = pc + XLEN'(4);
   assign trap_cause   = cause_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_FETCH;
         pc       <= RESET_PC;
         retired  <= '0;
         trap     <= 1'b0;
         cause_q  <= TC_ILLEGAL;
         wait_cnt <= '0;
         target_q <= '0;
         wb_sel_q <= WB_ALU;
         writes_q <= 1'b0;
         store_q  <= 1'b0;
      end else begin
         case (state)
            // Fetch and memory phases share the ack-or-timeout wait; ack on the last cycle wins.
            ST_FETCH, ST_MEM: begin
               if (mem_ack) begin
                  state    <= (state == ST_FETCH) ? ST_DECODE : ST_WB;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= ST_TRAP;
                  trap    <= 1'b1;
                  cause_q <= TC_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_DECODE: state <= ST_EXEC;
            ST_EXEC: begin
               if (!op_legal(opcode)) begin
                  state   <= ST_TRAP;
                  trap    <= 1'b1;
                  cause_q <= TC_ILLEGAL;
               end else if (misaligned_c) begin
                  state   <= ST_TRAP;
                  trap    <= 1'b1;
                  cause_q <= TC_MISALIGN;
               end else begin
                  target_q <= target_c;
                  wb_sel_q <= op_wb_sel(opcode);
                  writes_q <= op_writes(opcode);
                  store_q  <= (opcode == OP_STORE);
                  wait_cnt <= '0;
                  state    <= ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? ST_MEM : ST_WB;
               end
            end
            ST_WB: begin
               pc       <= target_q;
               retired  <= retired + CNT_W'(1);
               wait_cnt <= '0;
               state    <= ST_FETCH;
            end
            ST_TRAP: state <= ST_TRAP;
            default: state <= ST_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Table-driven bench for rv_multicycle_ctrl: the bench acts as memory, expectations go through a queue.
module tb_rv_multicycle_ctrl;
   import rv_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 32;
   localparam int BOUND = 60;
   localparam int NROWS = 18;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       opcode;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1_val;
   logic             cmp_flag;
   logic             mem_ack;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_plus4;
   logic             mem_req;
   logic             mem_we;
   logic             mem_addr_sel;
   logic             ir_load;
   logic             reg_we;
   logic [1:0]       wb_sel;
   logic             alu_src_b;
   logic [CNT_W-1:0] retired;
   logic             trap;
   logic [1:0]       trap_cause;

   always #5 clk = ~clk;

   rv_multicycle_ctrl #(
      .XLEN(XLEN), .RESET_PC(32'h0), .MEM_TIMEOUT(15), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imm(imm), .rs1_val(rs1_val),
      .cmp_flag(cmp_flag), .mem_ack(mem_ack), .pc(pc), .pc_plus4(pc_plus4),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_load(ir_load), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
      .retired(retired), .trap(trap), .trap_cause(trap_cause)
   );

   // Stimulus plus expected outcome; f_ack/m_ack = request cycle that gets the ack (0 = never).
   typedef struct {
      logic        rst_before;
      logic [6:0]  op;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        cmp;
      logic        noise;
      int          f_ack;
      int          m_ack;
      logic [31:0] e_pc;
      logic [31:0] e_ret;
      logic        e_trap;
      logic [1:0]  e_cause;
      int          e_regwe;
      logic [1:0]  e_wb;
      logic [31:0] e_link;
      logic        e_alub;
      logic        e_memwe;
      int          e_memc;
      int          e_fetchc;
      int          e_lat;
   } vec_t;

   vec_t tbl [NROWS];
   vec_t sb_q [$];

   int checks = 0;
   int errors = 0;
   int cur_row = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, cur_row, act, exp);
      end
   endtask

   // Asserts reset mid-cycle, checks reset values, releases on a falling edge.
   task automatic do_reset();
      rst = 1'b1;
      mem_ack = 1'b1;
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_ir_load", 32'(ir_load), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_cause", 32'(trap_cause), 32'd0);
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      rst = 1'b0;
   endtask

   // After a trap the core must stay silent and frozen even with mem_ack held high.
   task automatic trap_hold();
      int strobes = 0;
      logic [31:0] pc0, ret0;
      pc0 = pc;
      ret0 = retired;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ack = 1'b1;
         #1;
         strobes += int'(mem_req) + int'(mem_we) + int'(reg_we) + int'(ir_load);
      end
      mem_ack = 1'b0;
      chk("trap_hold_strobes", strobes, 32'd0);
      chk("trap_hold_trap", 32'(trap), 32'd1);
      chk("trap_hold_pc", pc, pc0);
      chk("trap_hold_retired", retired, ret0);
   endtask

   task automatic run_row(input vec_t v);
      vec_t e;
      logic [31:0] start_ret;
      logic [31:0] link_seen = '0;
      logic [1:0]  wb_seen = '0;
      logic        memwe_seen = 1'b0;
      int req_cnt = 0, ir_cyc = -1, end_cyc = -1, lat;
      int regwe = 0, memc = 0, fetchc = 0, inv_bad = 0;

      opcode = v.op;
      imm = v.imm;
      rs1_val = v.rs1;
      cmp_flag = v.cmp;
      sb_q.push_back(v);
      start_ret = retired;
      for (int c = 0; c < BOUND; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if ((retired != start_ret) || trap) begin
            end_cyc = c;
            if (trap) inv_bad += int'(mem_req) + int'(mem_we) + int'(reg_we) + int'(ir_load);
            break;
         end
         if (mem_req) req_cnt++;
         else req_cnt = 0;
         mem_ack = mem_req ? (req_cnt == (mem_addr_sel ? v.m_ack : v.f_ack)) : v.noise;
         #1;
         if (ir_load) ir_cyc = c;
         if (ir_load !== (mem_ack && mem_req && !mem_addr_sel)) inv_bad++;
         if (mem_we && !mem_req) inv_bad++;
         if (mem_req && !mem_addr_sel) fetchc++;
         if (mem_req && mem_addr_sel) memc++;
         if (mem_we) memwe_seen = 1'b1;
         if (reg_we) begin
            regwe++;
            wb_seen = wb_sel;
            link_seen = pc_plus4;
         end
      end
      mem_ack = 1'b0;

      e = sb_q.pop_front();
      if (end_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL row_bound row %0d: no retire or trap within %0d cycles", cur_row, BOUND);
      end
      lat = (ir_cyc < 0) ? 0 : end_cyc - ir_cyc;
      chk("pc", pc, e.e_pc);
      chk("retired", retired, e.e_ret);
      chk("trap", 32'(trap), 32'(e.e_trap));
      chk("trap_cause", 32'(trap_cause), 32'(e.e_cause));
      chk("reg_we_cycles", regwe, e.e_regwe);
      chk("mem_we_seen", 32'(memwe_seen), 32'(e.e_memwe));
      chk("mem_phase_cycles", memc, e.e_memc);
      chk("fetch_cycles", fetchc, e.e_fetchc);
      chk("latency", lat, e.e_lat);
      chk("alu_src_b", 32'(alu_src_b), 32'(e.e_alub));
      chk("strobe_rules", inv_bad, 32'd0);
      if (e.e_regwe != 0) begin
         chk("wb_sel", 32'(wb_seen), 32'(e.e_wb));
         chk("link", link_seen, e.e_link);
      end
      if (e.e_trap) trap_hold();
   endtask

   initial begin
      //          rst   op         imm            rs1        cmp   noise f  m   pc             ret    trap  cause regwe wb     link       alub  memwe memc fc lat
      tbl[0]  = '{1'b0, OP_I,      32'd5,         32'h0,     1'b0, 1'b0, 2, 0, 32'h4,         32'd1, 1'b0, 2'd0, 1, 2'd0, 32'h4,     1'b1, 1'b0, 0,  2, 4};
      tbl[1]  = '{1'b0, OP_LOAD,   32'd8,         32'h100,   1'b0, 1'b0, 1, 4, 32'h8,         32'd2, 1'b0, 2'd0, 1, 2'd1, 32'h8,     1'b1, 1'b0, 4,  1, 8};
      tbl[2]  = '{1'b0, OP_STORE,  32'd4,         32'h100,   1'b0, 1'b0, 3, 2, 32'hC,         32'd3, 1'b0, 2'd0, 0, 2'd0, 32'h0,     1'b1, 1'b1, 2,  3, 6};
      tbl[3]  = '{1'b0, OP_LUI,    32'h12345000,  32'h0,     1'b0, 1'b0, 1, 0, 32'h10,        32'd4, 1'b0, 2'd0, 1, 2'd3, 32'h10,    1'b1, 1'b0, 0,  1, 4};
      tbl[4]  = '{1'b0, OP_BRANCH, 32'hFFFFFFF8,  32'h0,     1'b1, 1'b0, 1, 0, 32'h8,         32'd5, 1'b0, 2'd0, 0, 2'd0, 32'h0,     1'b1, 1'b0, 0,  1, 4};
      tbl[5]  = '{1'b0, OP_BRANCH, 32'd6,         32'h0,     1'b0, 1'b0, 1, 0, 32'hC,         32'd6, 1'b0, 2'd0, 0, 2'd0, 32'h0,     1'b1, 1'b0, 0,  1, 4};
      tbl[6]  = '{1'b0, OP_R,      32'd0,         32'h0,     1'b0, 1'b1, 2, 0, 32'h10,        32'd7, 1'b0, 2'd0, 1, 2'd0, 32'h10,    1'b0, 1'b0, 0,  2, 4};
      tbl[7]  = '{1'b0, OP_JAL,    32'hFFFFFFEC,  32'h0,     1'b0, 1'b0, 1, 0, 32'hFFFFFFFC,  32'd8, 1'b0, 2'd0, 1, 2'd2, 32'h14,    1'b1, 1'b0, 0,  1, 4};
      tbl[8]  = '{1'b0, OP_JAL,    32'd4,         32'h0,     1'b0, 1'b0, 1, 0, 32'h0,         32'd9, 1'b0, 2'd0, 1, 2'd2, 32'h0,     1'b1, 1'b0, 0,  1, 4};
      tbl[9]  = '{1'b0, OP_AUIPC,  32'h1000,      32'h0,     1'b0, 1'b0, 1, 0, 32'h4,         32'd10,1'b0, 2'd0, 1, 2'd3, 32'h4,     1'b1, 1'b0, 0,  1, 4};
      tbl[10] = '{1'b0, OP_JALR,   32'd3,         32'h21,    1'b0, 1'b0, 1, 0, 32'h24,        32'd11,1'b0, 2'd0, 1, 2'd2, 32'h8,     1'b1, 1'b0, 0,  1, 4};
      tbl[11] = '{1'b0, OP_BRANCH, 32'd6,         32'h0,     1'b1, 1'b0, 1, 0, 32'h24,        32'd11,1'b1, 2'd1, 0, 2'd0, 32'h0,     1'b1, 1'b0, 0,  1, 3};
      tbl[12] = '{1'b1, 7'b1111111,32'd0,         32'h0,     1'b0, 1'b0, 1, 0, 32'h0,         32'd0, 1'b1, 2'd0, 0, 2'd0, 32'h0,     1'b1, 1'b0, 0,  1, 3};
      tbl[13] = '{1'b1, OP_JALR,   32'd0,         32'h103,   1'b0, 1'b0, 1, 0, 32'h0,         32'd0, 1'b1, 2'd1, 0, 2'd0, 32'h0,     1'b1, 1'b0, 0,  1, 3};
      tbl[14] = '{1'b1, OP_I,      32'd5,         32'h0,     1'b0, 1'b0, 0, 0, 32'h0,         32'd0, 1'b1, 2'd2, 0, 2'd0, 32'h0,     1'b1, 1'b0, 0, 15, 0};
      tbl[15] = '{1'b1, OP_I,      32'd5,         32'h0,     1'b0, 1'b0,15, 0, 32'h4,         32'd1, 1'b0, 2'd0, 1, 2'd0, 32'h4,     1'b1, 1'b0, 0, 15, 4};
      tbl[16] = '{1'b0, OP_LOAD,   32'd8,         32'h100,   1'b0, 1'b0, 1,15, 32'h8,         32'd2, 1'b0, 2'd0, 1, 2'd1, 32'h8,     1'b1, 1'b0, 15, 1, 19};
      tbl[17] = '{1'b0, OP_STORE,  32'd8,         32'h100,   1'b0, 1'b0, 1, 0, 32'h8,         32'd2, 1'b1, 2'd2, 0, 2'd0, 32'h0,     1'b1, 1'b1, 15, 1, 18};

      rst = 1'b0;
      opcode = OP_I;
      imm = '0;
      rs1_val = '0;
      cmp_flag = 1'b0;
      mem_ack = 1'b0;
      #2;
      do_reset();
      for (int i = 0; i < NROWS; i++) begin
         cur_row = i;
         if (tbl[i].rst_before) do_reset();
         run_row(tbl[i]);
      end

      // Reset landing in the middle of a fetch must drop mem_req without waiting for a clock edge.
      cur_row = NROWS;
      do_reset();
      #2;
      chk("req_before_async_rst", 32'(mem_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("req_async_drop", 32'(mem_req), 32'd0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
